// File: rtl/lsu_mem_ctrl_if.sv
// Bundles the pipeline request/response handshake and the data-memory port of the LSU.
// slave = the LSU side, master = the pipeline/memory side.
interface lsu_mem_ctrl_if #(
  parameter int size = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [size-1:0] req_addr;
  logic [size-1:0] req_wdata;
  logic            resp_valid;
  logic [size-1:0] resp_rdata;
  logic            resp_err;
  logic [size-1:0] mem_address;
  logic [size-1:0] mem_dataW;
  logic            mem_wr;
  logic [1:0]      mem_store_size;
  logic [2:0]      mem_load_size;
  logic [size-1:0] mem_dataR;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataR,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_dataW, mem_wr, mem_store_size, mem_load_size
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataR,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_dataW, mem_wr, mem_store_size, mem_load_size
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store initiator: aligned word reads with extraction, misaligned split into
// aligned cycles. Define MISALIGN_TRAP_EN to trap misaligned accesses instead of splitting.
module lsu_mem_ctrl #(
  parameter int size = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LD_HI, ST_BYTE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [size-1:0] addr_q, addr_d;
  logic [size-1:0] wdata_q, wdata_d;
  logic [size-1:0] lo_q, lo_d;
  logic [size-1:0] rdata_q, rdata_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
`ifdef MISALIGN_TRAP_EN
  logic            err_q, err_d;
`endif

  logic            accept;
  logic            size_ok;
  logic            ld_ok;
  logic            misalign;
  logic [size-1:0] ld_shift;
  logic [size-1:0] ld_combined;
  logic [1:0]      st_last;
  logic            wr_c;
`ifndef MISALIGN_TRAP_EN
  logic [2:0]      req_n;
  logic            straddle;
`endif

  function automatic logic [size-1:0] extend(input logic [size-1:0] raw, input logic [2:0] f3);
    case (f3)
      3'b000:  extend = {{(size-8){raw[7]}}, raw[7:0]};
      3'b001:  extend = {{(size-16){raw[15]}}, raw[15:0]};
      3'b010:  extend = raw;
      3'b100:  extend = {{(size-8){1'b0}}, raw[7:0]};
      3'b101:  extend = {{(size-16){1'b0}}, raw[15:0]};
      default: extend = '0;
    endcase
  endfunction

  assign accept   = bus.req_valid & bus.req_ready;
  assign size_ok  = (bus.req_funct3[1:0] != 2'b11);
  // 110 would be "lwu", which RV32I does not have
  assign ld_ok    = size_ok & ~(bus.req_funct3[2] & bus.req_funct3[1]);
  assign misalign = ((bus.req_funct3[1:0] == 2'b01) & bus.req_addr[0]) |
                    ((bus.req_funct3[1:0] == 2'b10) & (bus.req_addr[1:0] != 2'b00));
  assign ld_shift = bus.mem_dataR >> {bus.req_addr[1:0], 3'b000};
  assign st_last  = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;

`ifndef MISALIGN_TRAP_EN
  always_comb begin
    case (bus.req_funct3[1:0])
      2'b00:   req_n = 3'd1;
      2'b01:   req_n = 3'd2;
      2'b10:   req_n = 3'd4;
      default: req_n = 3'd0;
    endcase
  end
  assign straddle = (({1'b0, bus.req_addr[1:0]} + req_n) > 3'd4);
`endif

  // {hi, lo} >> 8*offset, keeping only the low word
  always_comb begin
    case (addr_q[1:0])
      2'd1:    ld_combined = {bus.mem_dataR[7:0],  lo_q[31:8]};
      2'd2:    ld_combined = {bus.mem_dataR[15:0], lo_q[31:16]};
      2'd3:    ld_combined = {bus.mem_dataR[23:0], lo_q[31:24]};
      default: ld_combined = lo_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      lo_q     <= lo_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
`ifdef MISALIGN_TRAP_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    lo_d     = lo_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          cnt_d    = 2'd0;
          rdata_d  = '0;
          valid_d  = 1'b1;
          if (bus.req_we) begin
`ifdef MISALIGN_TRAP_EN
            if (size_ok && misalign) err_d = 1'b1;
`else
            if (size_ok && misalign) begin
              valid_d = 1'b0;
              cnt_d   = 2'd1;
              state_d = ST_BYTE;
            end
`endif
          end else if (ld_ok) begin
`ifdef MISALIGN_TRAP_EN
            if (misalign) err_d = 1'b1;
            else          rdata_d = extend(ld_shift, bus.req_funct3);
`else
            if (straddle) begin
              valid_d = 1'b0;
              lo_d    = bus.mem_dataR;
              state_d = LD_HI;
            end else begin
              rdata_d = extend(ld_shift, bus.req_funct3);
            end
`endif
          end
        end
      end
      LD_HI: begin
        rdata_d = extend(ld_combined, funct3_q);
        valid_d = 1'b1;
        state_d = IDLE;
      end
      ST_BYTE: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == st_last) begin
          rdata_d = '0;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready      = (state_q == IDLE);
    bus.mem_load_size  = 3'b010;
    bus.mem_address    = {bus.req_addr[size-1:2], 2'b00};
    bus.mem_dataW      = bus.req_wdata;
    bus.mem_store_size = 2'b10;
    wr_c               = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_we) begin
          bus.mem_address = bus.req_addr;
          if (size_ok) begin
            if (misalign) begin
`ifndef MISALIGN_TRAP_EN
              bus.mem_dataW      = {{(size-8){1'b0}}, bus.req_wdata[7:0]};
              bus.mem_store_size = 2'b00;
              wr_c               = bus.req_valid;
`endif
            end else begin
              bus.mem_store_size = bus.req_funct3[1:0];
              wr_c               = bus.req_valid;
            end
          end
        end
      end
      LD_HI: bus.mem_address = {addr_q[size-1:2], 2'b00} + 32'd4;
      ST_BYTE: begin
        bus.mem_address    = addr_q + {{(size-2){1'b0}}, cnt_q};
        bus.mem_dataW      = {{(size-8){1'b0}}, wdata_q[{cnt_q, 3'b000} +: 8]};
        bus.mem_store_size = 2'b00;
        wr_c               = 1'b1;
      end
      default: ;
    endcase
    // write enable falls with reset even before the state register is observed
    bus.mem_wr = wr_c & rst_n;
  end

  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
`ifdef MISALIGN_TRAP_EN
  assign bus.resp_err   = err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: byte-array memory, byte-level reference model,
// directed scenarios plus randomized transactions.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.size(32)) bus ();
  lsu_mem_ctrl #(.size(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];
  int wr_count = 0;
  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] rd_base;
  assign rd_base = {bus.mem_address[11:2], 2'b00};
  assign bus.mem_dataR = {mem[rd_base + 12'd3], mem[rd_base + 12'd2],
                          mem[rd_base + 12'd1], mem[rd_base]};

  always @(posedge clk) begin : mem_write
    int nb;
    logic [11:0] a;
    if (bus.mem_wr) begin
      wr_count = wr_count + 1;
      a  = bus.mem_address[11:0];
      nb = (bus.mem_store_size == 2'b00) ? 1 : (bus.mem_store_size == 2'b01) ? 2 : 4;
      for (int i = 0; i < nb; i++) mem[a + 12'(i)] = bus.mem_dataW[8*i +: 8];
    end
  end

  task automatic poke(input logic [31:0] addr, input logic [31:0] word);
    for (int i = 0; i < 4; i++) begin
      mem[addr[11:0] + 12'(i)]     = word[8*i +: 8];
      ref_mem[addr[11:0] + 12'(i)] = word[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] peek(input logic [31:0] addr);
    peek = {mem[addr[11:0] + 12'd3], mem[addr[11:0] + 12'd2],
            mem[addr[11:0] + 12'd1], mem[addr[11:0]]};
  endfunction

  // Byte-level behavioural model: n bytes at addr..addr+n-1, little-endian.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output int lat, output logic err, output int nwr);
    int n;
    logic mis;
    logic [31:0] raw, ai;
    rdata = '0; lat = 1; err = 1'b0; nwr = 0;
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    if (n == 0 || (!we && f3 == 3'b110)) return;
`ifdef MISALIGN_TRAP_EN
    if (mis) begin err = 1'b1; return; end
`endif
    if (we) begin
      for (int i = 0; i < n; i++) begin
        ai = addr + 32'(i);
        ref_mem[ai[11:0]] = wdata[8*i +: 8];
      end
      nwr = mis ? n : 1;
      lat = mis ? n : 1;
    end else begin
      raw = '0;
      for (int i = 0; i < n; i++) begin
        ai  = addr + 32'(i);
        raw = raw | (32'(ref_mem[ai[11:0]]) << (8*i));
      end
      if (!f3[2] && n < 4 && raw[8*n-1]) raw = raw | (32'hFFFF_FFFF << (8*n));
      rdata = raw;
      lat   = (int'(addr[1:0]) + n > 4) ? 2 : 1;
    end
  endtask

  task automatic do_txn(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got);
    logic [31:0] exp_rdata;
    int exp_lat, exp_nwr, w0, cycles;
    logic exp_err;
    model(we, f3, addr, wdata, exp_rdata, exp_lat, exp_err, exp_nwr);
    @(negedge clk);
    w0 = wr_count;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr;  bus.req_wdata = wdata;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready: got %b expected 1", name, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cycles = 1;
    while (bus.resp_valid !== 1'b1 && cycles < 16) begin
      @(posedge clk); #1;
      cycles++;
    end
    got = bus.resp_rdata;
    $display("txn %s we=%0d f3=%03b addr=%h wdata=%h rdata=%h err=%b lat=%0d",
             name, we, f3, addr, wdata, got, bus.resp_err, cycles);
    n_checks++;
    if (cycles != exp_lat || bus.resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, cycles, exp_lat);
    end
    n_checks++;
    if (got !== exp_rdata) begin
      n_fail++; $display("FAIL %s rdata: got %h expected %h", name, got, exp_rdata);
    end
    n_checks++;
    if (bus.resp_err !== exp_err) begin
      n_fail++; $display("FAIL %s err: got %b expected %b", name, bus.resp_err, exp_err);
    end
    n_checks++;
    if (wr_count - w0 != exp_nwr) begin
      n_fail++; $display("FAIL %s writes: got %0d expected %0d", name, wr_count - w0, exp_nwr);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s pulse: got resp_valid %b expected 0", name, bus.resp_valid);
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_wr} !== 4'b1000 ||
        bus.resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: got ready/valid/err/wr=%b%b%b%b rdata=%h expected 1000 rdata=0",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_wr, bus.resp_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_loads();
    logic [31:0] got;
    poke(32'h100, 32'hDEADBEEF);
    do_txn("lw_aligned", 1'b0, 3'b010, 32'h100, 32'h0, got);
    n_checks++;
    if (got !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_const: got %h expected deadbeef", got); end
    poke(32'h100, 32'h80123456);
    do_txn("lb_103", 1'b0, 3'b000, 32'h103, 32'h0, got);
    n_checks++;
    if (got !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_const: got %h expected ffffff80", got); end
    do_txn("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, got);
    n_checks++;
    if (got !== 32'h00000080) begin n_fail++; $display("FAIL lbu_const: got %h expected 00000080", got); end
    do_txn("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, got);
    n_checks++;
    if (got !== 32'h00008012) begin n_fail++; $display("FAIL lhu_const: got %h expected 00008012", got); end
    do_txn("lh_101", 1'b0, 3'b001, 32'h101, 32'h0, got);
  endtask

  task automatic test_straddle();
`ifndef MISALIGN_TRAP_EN
    logic [31:0] scratch;
    poke(32'h100, 32'h44332211);
    poke(32'h104, 32'h88776655);
    model(1'b0, 3'b010, 32'h102, 32'h0, scratch, n_checks, scratch[0], n_checks);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h102;
    #1;
    n_checks++;
    if (bus.mem_address !== 32'h100) begin n_fail++; $display("FAIL straddle_addr0: got %h expected 00000100", bus.mem_address); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.req_ready !== 1'b0 || bus.mem_address !== 32'h104 || bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL straddle_hi: got ready=%b addr=%h valid=%b expected 0 00000104 0",
                         bus.req_ready, bus.mem_address, bus.resp_valid);
    end
    @(posedge clk); #1;
    $display("txn straddle_lw addr=00000102 rdata=%h valid=%b", bus.resp_rdata, bus.resp_valid);
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h66554433 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL straddle_data: got valid=%b rdata=%h ready=%b expected 1 66554433 1",
                         bus.resp_valid, bus.resp_rdata, bus.req_ready);
    end
`endif
  endtask

  task automatic test_misaligned_store();
    logic [31:0] got;
    poke(32'h100, 32'h0);
    poke(32'h104, 32'h0);
    do_txn("sw_101", 1'b1, 3'b010, 32'h101, 32'hAABBCCDD, got);
`ifndef MISALIGN_TRAP_EN
    n_checks++;
    if (peek(32'h100) !== 32'hBBCCDD00 || peek(32'h104) !== 32'h000000AA) begin
      n_fail++; $display("FAIL sw_split_mem: got %h %h expected bbccdd00 000000aa", peek(32'h100), peek(32'h104));
    end
`endif
  endtask

  task automatic test_reset_mid();
`ifndef MISALIGN_TRAP_EN
    poke(32'h100, 32'h0);
    poke(32'h104, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h101; bus.req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    $display("txn reset_mid_sw addr=00000101 mem_wr=%b ready=%b", bus.mem_wr, bus.req_ready);
    n_checks++;
    if (bus.mem_wr !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_wr: got wr=%b ready=%b expected 0 1", bus.mem_wr, bus.req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_valid: got %b expected 0", bus.resp_valid); end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (peek(32'h100) !== 32'h00CCDD00 || peek(32'h104) !== 32'h0 ||
        bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_after: got %h %h ready=%b valid=%b expected 00ccdd00 00000000 1 0",
                         peek(32'h100), peek(32'h104), bus.req_ready, bus.resp_valid);
    end
    poke(32'h100, 32'h0);
    poke(32'h104, 32'h0);
`endif
  endtask

  task automatic test_trap();
`ifdef MISALIGN_TRAP_EN
    logic [31:0] got;
    poke(32'h100, 32'h0);
    do_txn("sh_101_trap", 1'b1, 3'b001, 32'h101, 32'h00001234, got);
    do_txn("sh_102", 1'b1, 3'b001, 32'h102, 32'h00001234, got);
    n_checks++;
    if (peek(32'h100) !== 32'h12340000) begin n_fail++; $display("FAIL trap_mem: got %h expected 12340000", peek(32'h100)); end
`endif
  endtask

  task automatic test_invalid_and_wrap();
    logic [31:0] got;
    poke(32'h140, 32'hCAFEF00D);
    do_txn("ld_011", 1'b0, 3'b011, 32'h140, 32'h0, got);
    do_txn("ld_110", 1'b0, 3'b110, 32'h140, 32'h0, got);
    do_txn("ld_111", 1'b0, 3'b111, 32'h140, 32'h0, got);
    do_txn("st_011", 1'b1, 3'b011, 32'h140, 32'h11111111, got);
    do_txn("st_111", 1'b1, 3'b111, 32'h141, 32'h22222222, got);
    n_checks++;
    if (peek(32'h140) !== 32'hCAFEF00D) begin n_fail++; $display("FAIL invalid_store_mem: got %h expected cafef00d", peek(32'h140)); end
    poke(32'hFFFFFFFC, 32'hA1B2C3D4);
    poke(32'h0, 32'h5566E7F8);
    do_txn("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, got);
    do_txn("lh_wrap", 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, got);
    do_txn("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFD, 32'h01020304, got);
    do_txn("lw_wrap2", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, got);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_prev, scratch;
    int lat, nwr, n;
    logic err, we, pending;
    logic [2:0] f3;
    logic [31:0] addr;
    logic [2:0] ld_codes [5];
    ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    pending = 1'b0;
    exp_prev = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pending) begin
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp_prev) begin
          n_fail++; $display("FAIL b2b_%0d: got valid=%b rdata=%h expected 1 %h", i, bus.resp_valid, bus.resp_rdata, exp_prev);
        end
      end
      we   = 1'($urandom_range(0, 1));
      f3   = we ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
      n    = 1 << f3[1:0];
      addr = (32'h300 + 32'($urandom_range(0, 31))) & ~32'(n - 1);
      scratch = $urandom;
      model(we, f3, addr, scratch, exp_prev, lat, err, nwr);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
      bus.req_addr = addr;  bus.req_wdata = scratch;
      $display("txn b2b_%0d we=%0d f3=%03b addr=%h wdata=%h expect=%h", i, we, f3, addr, scratch, exp_prev);
      n_checks++;
      if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, bus.req_ready); end
      pending = 1'b1;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp_prev) begin
      n_fail++; $display("FAIL b2b_last: got valid=%b rdata=%h expected 1 %h", bus.resp_valid, bus.resp_rdata, exp_prev);
    end
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", bus.resp_valid); end
  endtask

  task automatic test_random();
    logic [31:0] got;
    for (int a = 32'h1F8; a < 32'h250; a += 4) poke(32'(a), $urandom);
    for (int i = 0; i < 80; i++) begin
      do_txn($sformatf("rnd_%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'h200 + 32'($urandom_range(0, 63)), $urandom, got);
    end
    for (int a = 32'h1F8; a < 32'h250; a += 4) begin
      n_checks++;
      if (peek(32'(a)) !== {ref_mem[12'(a) + 12'd3], ref_mem[12'(a) + 12'd2],
                            ref_mem[12'(a) + 12'd1], ref_mem[12'(a)]}) begin
        n_fail++; $display("FAIL rnd_mem_%h: got %h expected %h", a, peek(32'(a)),
                           {ref_mem[12'(a) + 12'd3], ref_mem[12'(a) + 12'd2], ref_mem[12'(a) + 12'd1], ref_mem[12'(a)]});
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 4096; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    test_reset();
    test_loads();
    test_straddle();
    test_misaligned_store();
    test_reset_mid();
    test_trap();
    test_invalid_and_wrap();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
